// File: rtl/vga_char_scanner.sv
// vga_char_scanner
//   Raster-scan reader for a character buffer. Generates VGA timing and
//   drives the read coordinates in pixel order. The buffer's read_lit and
//   read_out_of_bounds answers become a registered 12-bit colour. The syncs
//   are registered in the same stage as the colour, so all of them line up.
//   One clk equals one pixel.
//
// Ports
//   clk                 pixel clock
//   rst                 synchronous reset, active low
//   read_hchar   [6:0]  character column sent to the buffer (hcount[9:3])
//   read_vchar   [5:0]  character row sent to the buffer (vcount[8:3])
//   read_hoffset [2:0]  pixel column inside the glyph (hcount[2:0])
//   read_voffset [2:0]  pixel row inside the glyph (vcount[2:0])
//   read_lit            buffer answer: the pixel is lit
//   read_out_of_bounds  buffer answer: the coordinates are outside the buffer
//   vga_rgb      [11:0] {r,g,b} colour, registered
//   vga_hsync           active-low hsync, registered
//   vga_vsync           active-low vsync, registered
//   frame_start         1-cycle pulse while pixel (0,0) is on vga_rgb
module vga_char_scanner #(
  parameter int unsigned p_h_visible = 640,
  parameter int unsigned p_h_front   = 16,
  parameter int unsigned p_h_sync    = 96,
  parameter int unsigned p_h_back    = 48,
  parameter int unsigned p_v_visible = 480,
  parameter int unsigned p_v_front   = 10,
  parameter int unsigned p_v_sync    = 2,
  parameter int unsigned p_v_back    = 33,
  parameter logic [11:0] p_fg_color  = 12'hFFF,
  parameter logic [11:0] p_bg_color  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  read_hchar,
  output logic [5:0]  read_vchar,
  output logic [2:0]  read_hoffset,
  output logic [2:0]  read_voffset,
  input  logic        read_lit,
  input  logic        read_out_of_bounds,
  output logic [11:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int unsigned HTot  = p_h_visible + p_h_front + p_h_sync + p_h_back;
  localparam int unsigned VTot  = p_v_visible + p_v_front + p_v_sync + p_v_back;
  localparam int unsigned HCntW = $clog2(HTot);
  localparam int unsigned VCntW = $clog2(VTot);
  // One extra bit, so a window end equal to the total still fits.
  localparam int unsigned HExtW = HCntW + 1;
  localparam int unsigned VExtW = VCntW + 1;

  localparam logic [HCntW-1:0] HLast = HCntW'(HTot - 1);
  localparam logic [VCntW-1:0] VLast = VCntW'(VTot - 1);

  localparam logic [HExtW-1:0] HVis       = HExtW'(p_h_visible);
  localparam logic [HExtW-1:0] HSyncStart = HExtW'(p_h_visible + p_h_front);
  localparam logic [HExtW-1:0] HSyncEnd   = HExtW'(p_h_visible + p_h_front + p_h_sync);
  localparam logic [VExtW-1:0] VVis       = VExtW'(p_v_visible);
  localparam logic [VExtW-1:0] VSyncStart = VExtW'(p_v_visible + p_v_front);
  localparam logic [VExtW-1:0] VSyncEnd   = VExtW'(p_v_visible + p_v_front + p_v_sync);

  // Scan counters
  logic [HCntW-1:0] hcount_q, hcount_d;
  logic [VCntW-1:0] vcount_q, vcount_d;

  // Output stage
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  // Stage 0 decode
  logic [HExtW-1:0] hcount_ext;
  logic [VExtW-1:0] vcount_ext;
  logic [9:0]       hpos;
  logic [8:0]       vpos;
  logic             visible;
  logic             in_hsync;
  logic             in_vsync;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      if (vcount_q == VLast) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 1'b1;
      end
    end else begin
      hcount_d = hcount_q + 1'b1;
    end
  end

  always_comb begin
    hcount_ext = HExtW'(hcount_q);
    vcount_ext = VExtW'(vcount_q);
    // Fixed-width views, so the buffer slices stay valid for any timing parameters.
    hpos       = 10'(hcount_q);
    vpos       = 9'(vcount_q);
    visible    = (hcount_ext < HVis) && (vcount_ext < VVis);
    in_hsync   = (hcount_ext >= HSyncStart) && (hcount_ext < HSyncEnd);
    in_vsync   = (vcount_ext >= VSyncStart) && (vcount_ext < VSyncEnd);
  end

  // The read coordinates are held at zero during blanking. Otherwise the
  // 6-bit row index would alias at vcount >= 512.
  always_comb begin
    read_hchar   = '0;
    read_vchar   = '0;
    read_hoffset = '0;
    read_voffset = '0;
    if (visible) begin
      read_hchar   = hpos[9:3];
      read_vchar   = vpos[8:3];
      read_hoffset = hpos[2:0];
      read_voffset = vpos[2:0];
    end
  end

  // Stage 1 next state. out_of_bounds takes priority over lit.
  always_comb begin
    rgb_d = '0;
    if (visible) begin
      if (read_out_of_bounds) begin
        rgb_d = p_bg_color;
      end else if (read_lit) begin
        rgb_d = p_fg_color;
      end else begin
        rgb_d = p_bg_color;
      end
    end
    hsync_d       = ~in_hsync;
    vsync_d       = ~in_vsync;
    frame_start_d = (hcount_q == '0) && (vcount_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_rgb     = rgb_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule
